des_arbiter: RTL and testbench
==============================

DES_ARBITER -- requirements
Module: des_arbiter

Interface
REQ-001 Parameter: NUM_CH, default 4, number of requester channels (2..8); CH_W = clog2(NUM_CH).
REQ-002 Parameter: KEY_W, default 64, width of the key as supplied by requesters, parity bits included.
REQ-003 Port: clk_in  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst_n_in  input  1  asynchronous active-low reset.
REQ-005 Port: req_valid_in  input  NUM_CH  per-channel request valid.
REQ-006 Port: req_mode_in  input  NUM_CH  per-channel mode: 0 encrypt, 1 decrypt.
REQ-007 Port: req_data_in  input  NUM_CH*64  per-channel 64-bit block; channel i at [64*i+63:64*i].
REQ-008 Port: req_key_in  input  NUM_CH*KEY_W  per-channel key; channel i at [KEY_W*i+KEY_W-1:KEY_W*i].
REQ-009 Port: req_ready_out  output  NUM_CH  per-channel accept; one-hot or zero.
REQ-010 Port: core_ready_in  input  1  DES core idle and able to accept a job.
REQ-011 Port: core_valid_out / core_mode_out  output  1/1  job start strobe and mode to the core.
REQ-012 Port: core_data_out / core_key_out  output  64/KEY_W  block and key to the core.
REQ-013 Port: core_done_in / core_data_in  input  1/64  core result strobe and result block.
REQ-014 Port: core_error_in  input  1  core key-check failure; job aborted.
REQ-015 Port: rsp_valid_out / rsp_ready_in  output/input  1/1  response handshake.
REQ-016 Port: rsp_ch_out / rsp_data_out / rsp_error_out  output  CH_W/64/1  response channel tag, result, error flag.
REQ-017 Port: busy_out  output  1  high in every state except S_IDLE.

Function
REQ-018 FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP; transitions are S_IDLE->S_ISSUE->S_WAIT->S_RESP->S_IDLE.
REQ-019 In S_IDLE with core_ready_in=1 and any req_valid_in bit set, req_ready_out is driven combinationally for the arbitration winner only; all other bits stay 0.
REQ-020 In S_IDLE, the same cycle as the winner's req_ready_out, the block latches the winner's channel index, mode, data and key, then moves to S_ISSUE.
REQ-021 In S_ISSUE, core_valid_out=1 for exactly one cycle (the cycle after acceptance) with the latched mode/data/key; the FSM then moves to S_WAIT.
REQ-022 core_mode_out, core_data_out and core_key_out hold the latched values from S_ISSUE until the next acceptance.
REQ-023 In S_WAIT, the block stays until core_done_in or core_error_in is sampled high; it has no timeout.
REQ-024 On core_done_in: latch core_data_in into rsp_data_out, set rsp_error_out=0, move to S_RESP.
REQ-025 On core_error_in: set rsp_data_out=0, set rsp_error_out=1, move to S_RESP.
REQ-026 If core_done_in and core_error_in are high in the same cycle, the error takes priority.
REQ-027 In S_RESP, rsp_valid_out=1 with rsp_ch_out equal to the latched channel.
REQ-028 rsp_valid_out, rsp_ch_out, rsp_data_out and rsp_error_out hold stable until rsp_ready_in=1; the transfer completes that cycle and the FSM returns to S_IDLE.
REQ-029 Response outputs are registered; rsp_valid_out rises the cycle after core_done_in or core_error_in.
REQ-030 Minimum back-to-back period is accept, issue, core latency, 1 cycle response, 1 cycle idle-arbitrate.
REQ-031 Round-robin: the search starts at pointer ptr and wraps modulo NUM_CH; on acceptance, ptr <= winner+1, wrapping from NUM_CH-1 to 0.
REQ-032 req_valid_in bits and core_done_in / core_error_in strobes arriving outside S_IDLE / S_WAIT respectively are ignored; req_ready_out stays 0 outside S_IDLE.
REQ-033 A requester dropping req_valid_in before it is granted is not committed; no state changes.
REQ-034 In S_IDLE with core_ready_in=0, no grant is issued, even with pending requests.

Reset
REQ-035 While rst_n_in=0, the FSM is asynchronously forced to S_IDLE at any point, including mid-job.
REQ-036 While rst_n_in=0: ptr=0, all latched registers =0, and all outputs =0, except req_ready_out, which follows REQ-019 with core_ready_in gated low.
REQ-037 An in-flight job is discarded on reset and no response is produced for it.

Configuration
REQ-038 Macro DES_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and ptr is not implemented; when undefined, round-robin per REQ-031 applies.

Verification
REQ-039 Single request: ch1 valid, mode 0, key 133457799BBCDFF1, data 0123456789ABCDEF; core model returns 85E813540F0AB405. Required: core_valid_out 1 cycle after grant; rsp ch=1, data 85E813540F0AB405, err=0.
REQ-040 Fairness: all 4 channels held valid for 8 jobs. Required: grant order 0,1,2,3,0,1,2,3. With DES_ARB_FIXED_PRIO_EN defined, grant order is 0 repeated.
REQ-041 Error path: core_error_in and core_done_in pulsed in the same cycle on a ch2 job. Required: rsp ch=2, err=1, data 0.
REQ-042 Backpressure: rsp_ready_in held 0 for 5 cycles with ch3 requesting meanwhile. Required: rsp outputs stable; req_ready_out[3]=0 until response accepted, then ch3 granted.
REQ-043 Reset mid-job: rst_n_in asserted in S_WAIT. Required: busy_out=0, no rsp_valid_out; next request from ch0 granted first (ptr=0).
REQ-044 Core not ready: core_ready_in=0 with ch0 valid. Required: no grant; grant occurs in the cycle core_ready_in rises.

Source files
------------

// File: rtl/des_arbiter.sv
// Round-robin arbiter that serialises NUM_CH requester channels onto one DES core.
// Define DES_ARB_FIXED_PRIO_EN to use fixed priority (lowest index wins) instead.
//
// state   | meaning
// S_IDLE  | arbitrate; grant the winner when the core is ready
// S_ISSUE | one-cycle start strobe to the core
// S_WAIT  | wait for core done or error
// S_RESP  | hold response until rsp_ready_in
module des_arbiter #(
  parameter int NUM_CH = 4,
  parameter int KEY_W  = 64,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       req_valid_in,
  input  logic [NUM_CH-1:0]       req_mode_in,
  input  logic [NUM_CH*64-1:0]    req_data_in,
  input  logic [NUM_CH*KEY_W-1:0] req_key_in,
  output logic [NUM_CH-1:0]       req_ready_out,
  input  logic                    core_ready_in,
  output logic                    core_valid_out,
  output logic                    core_mode_out,
  output logic [63:0]             core_data_out,
  output logic [KEY_W-1:0]        core_key_out,
  input  logic                    core_done_in,
  input  logic [63:0]             core_data_in,
  input  logic                    core_error_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic [CH_W-1:0]         rsp_ch_out,
  output logic [63:0]             rsp_data_out,
  output logic                    rsp_error_out,
  output logic                    busy_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             mode_q, mode_d;
  logic [63:0]      data_q, data_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [63:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  logic [CH_W-1:0]  win_idx;
  logic             win_found;
  logic             grant;

`ifdef DES_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_valid_in[k]) begin
        win_idx   = CH_W'(k);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CH_W:0]   rr_sum;
  logic [CH_W-1:0] rr_idx;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (rr_sum >= (CH_W+1)'(NUM_CH))
        rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      rr_idx = rr_sum[CH_W-1:0];
      if (req_valid_in[rr_idx]) begin
        win_idx   = rr_idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant)
      ptr_d = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + CH_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ptr_q <= '0;
    else           ptr_q <= ptr_d;
  end
`endif

  // Reset gates the grant so req_ready_out stays low while rst_n_in is low.
  assign grant = (state_q == S_IDLE) && core_ready_in && rst_n_in && win_found;

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    mode_d         = mode_q;
    data_d         = data_q;
    key_d          = key_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    req_ready_out  = '0;
    core_valid_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          req_ready_out[win_idx] = 1'b1;
          ch_d    = win_idx;
          mode_d  = req_mode_in[win_idx];
          data_d  = req_data_in[64*int'(win_idx) +: 64];
          key_d   = req_key_in[KEY_W*int'(win_idx) +: KEY_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_valid_out = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (core_error_in) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else if (core_done_in) begin
          rsp_data_d = core_data_in;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_in)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      mode_q     <= 1'b0;
      data_q     <= '0;
      key_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      key_q      <= key_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign core_mode_out = mode_q;
  assign core_data_out = data_q;
  assign core_key_out  = key_q;
  assign rsp_valid_out = (state_q == S_RESP);
  assign rsp_ch_out    = ch_q;
  assign rsp_data_out  = rsp_data_q;
  assign rsp_error_out = rsp_err_q;
  assign busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_des_arbiter.sv
// Directed self-checking bench for des_arbiter (NUM_CH=4, KEY_W=64).
module tb_des_arbiter;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [3:0]   req_valid_in;
  logic [3:0]   req_mode_in;
  logic [255:0] req_data_in;
  logic [255:0] req_key_in;
  logic [3:0]   req_ready_out;
  logic         core_ready_in;
  logic         core_valid_out;
  logic         core_mode_out;
  logic [63:0]  core_data_out;
  logic [63:0]  core_key_out;
  logic         core_done_in;
  logic [63:0]  core_data_in;
  logic         core_error_in;
  logic         rsp_valid_out;
  logic         rsp_ready_in;
  logic [1:0]   rsp_ch_out;
  logic [63:0]  rsp_data_out;
  logic         rsp_error_out;
  logic         busy_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk_in = ~clk_in;

  des_arbiter #(.NUM_CH(4), .KEY_W(64)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_valid_in(req_valid_in), .req_mode_in(req_mode_in),
    .req_data_in(req_data_in), .req_key_in(req_key_in),
    .req_ready_out(req_ready_out), .core_ready_in(core_ready_in),
    .core_valid_out(core_valid_out), .core_mode_out(core_mode_out),
    .core_data_out(core_data_out), .core_key_out(core_key_out),
    .core_done_in(core_done_in), .core_data_in(core_data_in),
    .core_error_in(core_error_in), .rsp_valid_out(rsp_valid_out),
    .rsp_ready_in(rsp_ready_in), .rsp_ch_out(rsp_ch_out),
    .rsp_data_out(rsp_data_out), .rsp_error_out(rsp_error_out),
    .busy_out(busy_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Runs one job from S_IDLE to completion; reports granted channel (-1 if none) and response.
  task automatic serve_job(input bit drop, input logic [63:0] res, input logic done_v,
                           input logic err_v, output int gch, output logic rvld,
                           output logic [1:0] rch, output logic [63:0] rdata, output logic rerr);
    gch = -1; rvld = 1'b0; rch = '0; rdata = '0; rerr = 1'b0;
    for (int i = 0; i < 20 && gch < 0; i++) begin
      #1;
      for (int c = 0; c < 4; c++) if (req_ready_out[c]) gch = c;
      if (gch < 0) tick();
    end
    if (gch >= 0) begin
      tick();
      if (drop) req_valid_in[gch] = 1'b0;
      tick();
      core_data_in = res; core_done_in = done_v; core_error_in = err_v;
      tick();
      core_done_in = 1'b0; core_error_in = 1'b0;
      rvld = rsp_valid_out; rch = rsp_ch_out; rdata = rsp_data_out; rerr = rsp_error_out;
      rsp_ready_in = 1'b1;
      tick();
      rsp_ready_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    req_valid_in = 4'hF;
    #3;
    total_cnt++; if (req_ready_out !== 4'b0000) $display("FAIL rst_ready: got %b want %b", req_ready_out, 4'b0000); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_out); else pass_cnt++;
    total_cnt++; if ({core_valid_out, rsp_valid_out, rsp_error_out} !== 3'b000) $display("FAIL rst_valids: got %b want 000", {core_valid_out, rsp_valid_out, rsp_error_out}); else pass_cnt++;
    total_cnt++; if ({core_data_out, core_key_out, rsp_data_out} !== 192'd0) $display("FAIL rst_data: got %h want 0", {core_data_out, core_key_out, rsp_data_out}); else pass_cnt++;
    tick(); tick();
    req_valid_in = 4'h0;
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_fairness();
    int gch; logic v; logic [1:0] c; logic [63:0] d; logic e; int exp;
    req_valid_in = 4'hF;
    for (int j = 0; j < 8; j++) begin
`ifdef DES_ARB_FIXED_PRIO_EN
      exp = 0;
`else
      exp = j % 4;
`endif
      serve_job(1'b0, 64'h1000 + 64'(j), 1'b1, 1'b0, gch, v, c, d, e);
      total_cnt++; if (gch !== exp) $display("FAIL fair_grant%0d: got %0d want %0d", j, gch, exp); else pass_cnt++;
      total_cnt++; if ({v, c, d} !== {1'b1, 2'(exp), 64'h1000 + 64'(j)}) $display("FAIL fair_rsp%0d: got %h want %h", j, {v, c, d}, {1'b1, 2'(exp), 64'h1000 + 64'(j)}); else pass_cnt++;
    end
    req_valid_in = 4'h0;
    tick();
  endtask

  task automatic test_single();
    req_valid_in = 4'b0010;
    #1;
    total_cnt++; if (req_ready_out !== 4'b0010) $display("FAIL single_grant: got %b want 0010", req_ready_out); else pass_cnt++;
    tick();
    req_valid_in = 4'b0000;
    total_cnt++; if (core_valid_out !== 1'b1) $display("FAIL single_core_valid: got %b want 1", core_valid_out); else pass_cnt++;
    total_cnt++; if ({core_mode_out, core_data_out, core_key_out} !== {1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1}) $display("FAIL single_core_job: got %h want %h", {core_mode_out, core_data_out, core_key_out}, {1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1}); else pass_cnt++;
    tick();
    total_cnt++; if ({core_valid_out, busy_out, req_ready_out} !== 6'b010000) $display("FAIL single_one_pulse: got %b want 010000", {core_valid_out, busy_out, req_ready_out}); else pass_cnt++;
    total_cnt++; if (core_data_out !== 64'h0123456789ABCDEF) $display("FAIL single_hold: got %h want 0123456789abcdef", core_data_out); else pass_cnt++;
    core_data_in = 64'h85E813540F0AB405; core_done_in = 1'b1;
    tick();
    core_done_in = 1'b0;
    total_cnt++; if ({rsp_valid_out, rsp_ch_out, rsp_error_out} !== 4'b1010) $display("FAIL single_rsp_ctl: got %b want 1010", {rsp_valid_out, rsp_ch_out, rsp_error_out}); else pass_cnt++;
    total_cnt++; if (rsp_data_out !== 64'h85E813540F0AB405) $display("FAIL single_rsp_data: got %h want 85e813540f0ab405", rsp_data_out); else pass_cnt++;
    rsp_ready_in = 1'b1;
    tick();
    rsp_ready_in = 1'b0;
    total_cnt++; if ({rsp_valid_out, busy_out} !== 2'b00) $display("FAIL single_done: got %b want 00", {rsp_valid_out, busy_out}); else pass_cnt++;
  endtask

  task automatic test_error();
    int gch; logic v; logic [1:0] c; logic [63:0] d; logic e;
    req_valid_in = 4'b0100;
    req_mode_in  = 4'b0100;
    serve_job(1'b1, 64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, gch, v, c, d, e);
    total_cnt++; if (gch !== 2) $display("FAIL err_grant: got %0d want 2", gch); else pass_cnt++;
    total_cnt++; if ({v, c, e} !== 4'b1101) $display("FAIL err_rsp_ctl: got %b want 1101", {v, c, e}); else pass_cnt++;
    total_cnt++; if (d !== 64'd0) $display("FAIL err_rsp_data: got %h want 0", d); else pass_cnt++;
    req_mode_in = 4'b0000;
  endtask

  task automatic test_backpressure();
    int gch; logic v; logic [1:0] c; logic [63:0] d; logic e;
    req_valid_in = 4'b0001;
    #1;
    total_cnt++; if (req_ready_out !== 4'b0001) $display("FAIL bp_grant0: got %b want 0001", req_ready_out); else pass_cnt++;
    tick();
    req_valid_in = 4'b1000;
    tick();
    core_data_in = 64'hA5A5A5A55A5A5A5A; core_done_in = 1'b1;
    tick();
    core_done_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if ({rsp_valid_out, rsp_ch_out, rsp_error_out, rsp_data_out} !== {4'b1000, 64'hA5A5A5A55A5A5A5A}) $display("FAIL bp_hold%0d: got %h want %h", i, {rsp_valid_out, rsp_ch_out, rsp_error_out, rsp_data_out}, {4'b1000, 64'hA5A5A5A55A5A5A5A}); else pass_cnt++;
      total_cnt++; if (req_ready_out[3] !== 1'b0) $display("FAIL bp_no_grant%0d: got %b want 0", i, req_ready_out[3]); else pass_cnt++;
      tick();
    end
    rsp_ready_in = 1'b1;
    tick();
    rsp_ready_in = 1'b0;
    total_cnt++; if (req_ready_out !== 4'b1000) $display("FAIL bp_grant3: got %b want 1000", req_ready_out); else pass_cnt++;
    serve_job(1'b1, 64'h3333, 1'b1, 1'b0, gch, v, c, d, e);
    total_cnt++; if ({gch, c} !== {32'd3, 2'd3}) $display("FAIL bp_job3: got %0d/%0d want 3/3", gch, c); else pass_cnt++;
  endtask

  task automatic test_core_not_ready();
    int gch; logic v; logic [1:0] c; logic [63:0] d; logic e;
    core_ready_in = 1'b0;
    req_valid_in  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if ({req_ready_out, busy_out} !== 5'b00000) $display("FAIL cnr_no_grant%0d: got %b want 00000", i, {req_ready_out, busy_out}); else pass_cnt++;
      tick();
    end
    core_ready_in = 1'b1;
    #1;
    total_cnt++; if (req_ready_out !== 4'b0001) $display("FAIL cnr_grant: got %b want 0001", req_ready_out); else pass_cnt++;
    serve_job(1'b1, 64'h0, 1'b1, 1'b0, gch, v, c, d, e);
    total_cnt++; if (gch !== 0) $display("FAIL cnr_job: got %0d want 0", gch); else pass_cnt++;
  endtask

  task automatic test_drop();
    core_ready_in = 1'b0;
    req_valid_in  = 4'b0100;
    tick();
    req_valid_in  = 4'b0000;
    core_ready_in = 1'b1;
    #1;
    total_cnt++; if (req_ready_out !== 4'b0000) $display("FAIL drop_ready: got %b want 0000", req_ready_out); else pass_cnt++;
    tick();
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy_out); else pass_cnt++;
  endtask

  task automatic test_reset_mid_job();
    int gch; logic v; logic [1:0] c; logic [63:0] d; logic e;
    req_valid_in = 4'b0010;
    #1;
    tick();
    req_valid_in = 4'b0000;
    tick();
    total_cnt++; if (busy_out !== 1'b1) $display("FAIL rmj_busy_wait: got %b want 1", busy_out); else pass_cnt++;
    rst_n_in = 1'b0;
    #1;
    total_cnt++; if ({busy_out, rsp_valid_out, core_valid_out} !== 3'b000) $display("FAIL rmj_in_reset: got %b want 000", {busy_out, rsp_valid_out, core_valid_out}); else pass_cnt++;
    core_data_in = 64'h7777; core_done_in = 1'b1;
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
    core_done_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if ({rsp_valid_out, busy_out} !== 2'b00) $display("FAIL rmj_no_rsp%0d: got %b want 00", i, {rsp_valid_out, busy_out}); else pass_cnt++;
      tick();
    end
    req_valid_in = 4'hF;
    #1;
    total_cnt++; if (req_ready_out !== 4'b0001) $display("FAIL rmj_ptr0: got %b want 0001", req_ready_out); else pass_cnt++;
    serve_job(1'b0, 64'h1, 1'b1, 1'b0, gch, v, c, d, e);
    total_cnt++; if ({gch, v, c} !== {32'd0, 1'b1, 2'd0}) $display("FAIL rmj_job: got %0d/%b/%0d want 0/1/0", gch, v, c); else pass_cnt++;
    req_valid_in = 4'h0;
  endtask

  initial begin
    req_valid_in  = '0;
    req_mode_in   = '0;
    req_data_in   = {64'h3030303030303030, 64'h2020202020202020, 64'h0123456789ABCDEF, 64'h0000000000000000};
    req_key_in    = {64'hCCCCCCCCCCCCCCCC, 64'hBBBBBBBBBBBBBBBB, 64'h133457799BBCDFF1, 64'hAAAAAAAAAAAAAAAA};
    core_ready_in = 1'b1;
    core_done_in  = 1'b0;
    core_error_in = 1'b0;
    core_data_in  = '0;
    rsp_ready_in  = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_error();
    test_backpressure();
    test_core_not_ready();
    test_drop();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

endmodule
